memory_access: RTL

MEM stage of the 5-stage RV32 pipeline: sits directly downstream of `execute` and upstream of writeback. Consumes the EX/MEM pipeline registers and drives a request/ready data-memory port. Byte lanes and write strobes are generated on stores; load data is aligned and sign/zero-extended. Produces the MEM/WB pipeline registers. Asserts a stall to the hazard unit while a memory access is outstanding, and buffers a completed response while downstream is held.

---
 rtl/memory_access_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 44 ++++
 rtl/memory_access.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - size codes, MemRW bit positions, FSM encoding and timeout default for the MEM stage
package memory_access_pkg;

   localparam logic [1:0] DSIZE_BYTE = 2'b00;
   localparam logic [1:0] DSIZE_HALF = 2'b01;
   localparam logic [1:0] DSIZE_WORD = 2'b10;

   localparam int MEMRW_STORE = 0;
   localparam int MEMRW_LOAD  = 1;

   localparam int TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store byte-lane/strobe generation and load shift/extend
module mem_lane_align
   import memory_access_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  dsize,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [1:0]  offset;
   logic [31:0] shifted;

   // Address bits below the access size are ignored, so offset drops them.
   always_comb begin
      offset = 2'b00;
      be     = 4'b1111;
      wdata  = store_data;
      case (dsize)
         DSIZE_BYTE: begin
            offset = addr_lo;
            be     = 4'b0001 << addr_lo;
            wdata  = {4{store_data[7:0]}};
         end
         DSIZE_HALF: begin
            offset = {addr_lo[1], 1'b0};
            be     = 4'b0011 << {addr_lo[1], 1'b0};
            wdata  = {2{store_data[15:0]}};
         end
         default: ;
      endcase
      shifted = rdata >> {offset, 3'b000};
      case (dsize)
         DSIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         DSIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default:    load_data = shifted;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32 MEM stage with req/ready data port, timeout and HOLD buffer; optional MEM_MISALIGN_TRAP_EN
module memory_access
   import memory_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        keep,
   input  logic        nop,
   input  logic [31:0] ALU_co_pype,
   input  logic [31:0] read_data2_pype2,
   input  logic [4:0]  WReg_pype2,
   input  logic [2:0]  writeback_control_pype2,
   input  logic [31:0] PCp4_pype2,
   input  logic [2:0]  funct3_pype2,
   input  logic [1:0]  MemRW_pype2,
   input  logic [1:0]  dsize_pype2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] ALU_co_pype3,
   output logic [31:0] load_data_pype3,
   output logic [31:0] PCp4_pype3,
   output logic [4:0]  WReg_pype3,
   output logic [2:0]  writeback_control_pype3,
   output logic        bus_err_pype3,
   output logic        exc_misalign_pype3,
   output logic [31:0] mem_badaddr_pype3
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic [31:0] cap_alu, cap_data, cap_pc;
   logic [4:0]  cap_wreg;
   logic [2:0]  cap_wbc;
   logic [1:0]  cap_dsize;
   logic        cap_uns, cap_st, cap_ld;
   logic [31:0] buf_load;
   logic        buf_err;

   logic        use_cap, sel_uns, sel_st, sel_ld;
   logic [31:0] sel_alu, sel_data, sel_pc;
   logic [4:0]  sel_wreg;
   logic [2:0]  sel_wbc;
   logic [1:0]  sel_dsize;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_load;

   logic        req, stall, cap_en, buf_en, wb_en, wb_clr, res_err;
   logic [31:0] res_load;
   logic [2:0]  res_wbc;
   logic        unused_funct3;

   assign unused_funct3 = ^funct3_pype2[1:0];

   // Outside IDLE the request and the pass-through fields come from the capture registers.
   assign use_cap   = (state != ST_IDLE);
   assign sel_alu   = use_cap ? cap_alu   : ALU_co_pype;
   assign sel_data  = use_cap ? cap_data  : read_data2_pype2;
   assign sel_pc    = use_cap ? cap_pc    : PCp4_pype2;
   assign sel_wreg  = use_cap ? cap_wreg  : WReg_pype2;
   assign sel_wbc   = use_cap ? cap_wbc   : writeback_control_pype2;
   assign sel_dsize = use_cap ? cap_dsize : dsize_pype2;
   assign sel_uns   = use_cap ? cap_uns   : funct3_pype2[2];
   assign sel_st    = use_cap ? cap_st    : MemRW_pype2[MEMRW_STORE];
   assign sel_ld    = use_cap ? cap_ld    : MemRW_pype2[MEMRW_LOAD];

   mem_lane_align u_lane (
      .addr_lo     (sel_alu[1:0]),
      .dsize       (sel_dsize),
      .is_unsigned (sel_uns),
      .store_data  (sel_data),
      .rdata       (dmem_rdata),
      .be          (lane_be),
      .wdata       (lane_wdata),
      .load_data   (lane_load)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign, res_exc;
   assign misalign = ((dsize_pype2 == DSIZE_HALF) && ALU_co_pype[0]) ||
                     ((dsize_pype2 == DSIZE_WORD) && (ALU_co_pype[1:0] != 2'b00));
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req        = 1'b0;
      stall      = 1'b0;
      cap_en     = 1'b0;
      buf_en     = 1'b0;
      wb_en      = 1'b0;
      wb_clr     = 1'b0;
      res_err    = 1'b0;
      res_load   = sel_ld ? lane_load : 32'd0;
      res_wbc    = sel_wbc;
`ifdef MEM_MISALIGN_TRAP_EN
      res_exc    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!keep) begin
               if (nop) begin
                  wb_clr = 1'b1;
               end else if (|MemRW_pype2) begin
`ifdef MEM_MISALIGN_TRAP_EN
                  if (misalign) begin
                     wb_en    = 1'b1;
                     res_exc  = 1'b1;
                     res_load = 32'd0;
                     res_wbc  = 3'd0;
                  end else
`endif
                  begin
                     req = 1'b1;
                     if (dmem_ready) begin
                        wb_en = 1'b1;
                     end else begin
                        cap_en     = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_WAIT;
                     end
                  end
               end else begin
                  wb_en = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem_ready || (cnt == TIMEOUT_LAST)) begin
               cnt_next = 8'd0;
               res_err  = ~dmem_ready;
               if (!dmem_ready) begin
                  res_load = 32'd0;
                  res_wbc  = 3'd0;
               end
               if (keep) begin
                  buf_en     = 1'b1;
                  state_next = ST_HOLD;
               end else begin
                  wb_en      = 1'b1;
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         ST_HOLD: begin
            stall    = 1'b1;
            res_err  = buf_err;
            res_load = buf_load;
            if (buf_err) res_wbc = 3'd0;
            if (!keep) begin
               wb_en      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign dmem_req   = rst & req;
   assign mem_stall  = rst & stall;
   assign dmem_we    = dmem_req & sel_st;
   assign dmem_addr  = dmem_req ? {sel_alu[31:2], 2'b00} : 32'd0;
   assign dmem_wdata = dmem_req ? lane_wdata : 32'd0;
   assign dmem_be    = dmem_req ? lane_be : 4'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                   <= ST_IDLE;
         cnt                     <= 8'd0;
         cap_alu                 <= 32'd0;
         cap_data                <= 32'd0;
         cap_pc                  <= 32'd0;
         cap_wreg                <= 5'd0;
         cap_wbc                 <= 3'd0;
         cap_dsize               <= 2'd0;
         cap_uns                 <= 1'b0;
         cap_st                  <= 1'b0;
         cap_ld                  <= 1'b0;
         buf_load                <= 32'd0;
         buf_err                 <= 1'b0;
         ALU_co_pype3            <= 32'd0;
         load_data_pype3         <= 32'd0;
         PCp4_pype3              <= 32'd0;
         WReg_pype3              <= 5'd0;
         writeback_control_pype3 <= 3'd0;
         bus_err_pype3           <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         exc_misalign_pype3      <= 1'b0;
         mem_badaddr_pype3       <= 32'd0;
`endif
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (cap_en) begin
            cap_alu   <= ALU_co_pype;
            cap_data  <= read_data2_pype2;
            cap_pc    <= PCp4_pype2;
            cap_wreg  <= WReg_pype2;
            cap_wbc   <= writeback_control_pype2;
            cap_dsize <= dsize_pype2;
            cap_uns   <= funct3_pype2[2];
            cap_st    <= MemRW_pype2[MEMRW_STORE];
            cap_ld    <= MemRW_pype2[MEMRW_LOAD];
         end
         if (buf_en) begin
            buf_load <= res_load;
            buf_err  <= res_err;
         end
         if (wb_clr) begin
            ALU_co_pype3            <= 32'd0;
            load_data_pype3         <= 32'd0;
            PCp4_pype3              <= 32'd0;
            WReg_pype3              <= 5'd0;
            writeback_control_pype3 <= 3'd0;
            bus_err_pype3           <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_misalign_pype3      <= 1'b0;
            mem_badaddr_pype3       <= 32'd0;
`endif
         end else if (wb_en) begin
            ALU_co_pype3            <= sel_alu;
            load_data_pype3         <= res_load;
            PCp4_pype3              <= sel_pc;
            WReg_pype3              <= sel_wreg;
            writeback_control_pype3 <= res_wbc;
            bus_err_pype3           <= res_err;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_misalign_pype3      <= res_exc;
            mem_badaddr_pype3       <= res_exc ? ALU_co_pype : 32'd0;
`endif
         end
      end
   end

`ifndef MEM_MISALIGN_TRAP_EN
   assign exc_misalign_pype3 = 1'b0;
   assign mem_badaddr_pype3  = 32'd0;
`endif

endmodule
